// File: rtl/pixel_writer_if.sv
// Pixel request / VGA write bus for pixel_writer.
// master: the pixel source and observer. slave: the pixel_writer block.
interface pixel_writer_if;
  logic       in_valid;
  logic [7:0] in_x;
  logic [6:0] in_y;
  logic [2:0] in_colour;
  logic       clear_req;
  logic       in_ready;
  logic       plot;
  logic [7:0] out_x;
  logic [6:0] out_y;
  logic [2:0] out_colour;
  logic       busy;
  logic       clear_done;
  logic [7:0] drop_count;

  modport master (
    output in_valid, in_x, in_y, in_colour, clear_req,
    input  in_ready, plot, out_x, out_y, out_colour, busy, clear_done, drop_count
  );

  modport slave (
    input  in_valid, in_x, in_y, in_colour, clear_req,
    output in_ready, plot, out_x, out_y, out_colour, busy, clear_done, drop_count
  );
endinterface

// File: rtl/pixel_writer.sv
// pixel_writer: buffers pixel writes in a 4-entry FIFO and streams them to a
// 160x120 VGA adapter one per cycle; can also sweep the whole screen to
// colour 0 after draining pending pixels.
// Optional macro PIXEL_WRITER_CLIP_EN: off-screen pixels are accepted but
// discarded and counted in drop_count (saturating at 255).
module pixel_writer (
  input  logic         clock,
  input  logic         reset,
  pixel_writer_if.slave pw
);
  localparam logic [7:0] X_MAX = 8'd159;
  localparam logic [6:0] Y_MAX = 7'd119;

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_CLEAR} state_t;

  state_t      state_q;
  logic [17:0] mem_q [4];
  logic [1:0]  wr_ptr_q;
  logic [1:0]  rd_ptr_q;
  logic [2:0]  count_q;
  logic [2:0]  count_d;
  logic        clear_pend_q;
  logic [7:0]  sweep_x_q;
  logic [6:0]  sweep_y_q;
  logic        plot_q;
  logic        clear_done_q;
  logic [7:0]  out_x_q;
  logic [6:0]  out_y_q;
  logic [2:0]  out_colour_q;

  logic        fifo_empty;
  logic        accept;
  logic        clip;
  logic        push;
  logic        pop;
  logic [17:0] head;

  assign fifo_empty = (count_q == 3'd0);
  assign pw.in_ready = (count_q < 3'd4) && (state_q != S_CLEAR) && !clear_pend_q;
  assign accept     = pw.in_valid && pw.in_ready;

`ifdef PIXEL_WRITER_CLIP_EN
  localparam logic [7:0] X_LIM = 8'd160;
  localparam logic [6:0] Y_LIM = 7'd120;
  assign clip = (pw.in_x >= X_LIM) || (pw.in_y >= Y_LIM);
`else
  assign clip = 1'b0;
`endif

  assign push = accept && !clip;
  assign pop  = (state_q == S_DRAIN) && !fifo_empty;
  assign head = mem_q[rd_ptr_q];

  // FIFO occupancy after this cycle's push/pop (both at once leaves it unchanged)
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  // FIFO storage; contents are don't-care until the pointers say otherwise
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= {pw.in_x, pw.in_y, pw.in_colour};
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
      count_q <= count_d;
    end
  end

`ifdef PIXEL_WRITER_CLIP_EN
  logic [7:0] drop_q;

  // Count accepted-but-clipped pixels, sticking at 255
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      drop_q <= 8'd0;
    end else if (accept && clip && (drop_q != 8'hFF)) begin
      drop_q <= drop_q + 8'd1;
    end
  end

  assign pw.drop_count = drop_q;
`else
  assign pw.drop_count = 8'd0;
`endif

  // Control FSM with registered VGA outputs: drain FIFO, then run any pending clear sweep
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      clear_pend_q <= 1'b0;
      sweep_x_q    <= 8'd0;
      sweep_y_q    <= 7'd0;
      plot_q       <= 1'b0;
      clear_done_q <= 1'b0;
      out_x_q      <= 8'd0;
      out_y_q      <= 7'd0;
      out_colour_q <= 3'd0;
    end else begin
      plot_q       <= 1'b0;
      clear_done_q <= 1'b0;
      // A request during an active sweep is dropped; a repeat while pending is a no-op
      if (pw.clear_req && (state_q != S_CLEAR)) clear_pend_q <= 1'b1;

      case (state_q)
        S_IDLE: begin
          if (!fifo_empty) begin
            state_q <= S_DRAIN;
          end else if (clear_pend_q) begin
            state_q   <= S_CLEAR;
            sweep_x_q <= 8'd0;
            sweep_y_q <= 7'd0;
          end
        end
        S_DRAIN: begin
          if (pop) begin
            plot_q                             <= 1'b1;
            {out_x_q, out_y_q, out_colour_q}   <= head;
          end else if (clear_pend_q) begin
            state_q   <= S_CLEAR;
            sweep_x_q <= 8'd0;
            sweep_y_q <= 7'd0;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_CLEAR: begin
          plot_q       <= 1'b1;
          out_x_q      <= sweep_x_q;
          out_y_q      <= sweep_y_q;
          out_colour_q <= 3'd0;
          if (sweep_x_q == X_MAX) begin
            sweep_x_q <= 8'd0;
            if (sweep_y_q == Y_MAX) begin
              sweep_y_q    <= 7'd0;
              clear_done_q <= 1'b1;
              clear_pend_q <= 1'b0;
              state_q      <= S_IDLE;
            end else begin
              sweep_y_q <= sweep_y_q + 7'd1;
            end
          end else begin
            sweep_x_q <= sweep_x_q + 8'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign pw.plot       = plot_q;
  assign pw.out_x      = out_x_q;
  assign pw.out_y      = out_y_q;
  assign pw.out_colour = out_colour_q;
  assign pw.clear_done = clear_done_q;
  assign pw.busy       = !fifo_empty || clear_pend_q || (state_q != S_IDLE);
endmodule
